mem_arbiter: RTL and testbench

- Shares the single two-way set-associative memory system (cache plus four-bank memory) between the instruction-fetch port and the data-memory port of the processor.
- Accepts one request at a time from each side, serialises them onto the memory system's Rd/Wr/Done handshake, and returns read data and hit status to the winning requester.
- Round-robin arbitration when both ports request in the same cycle.
- Watchdog flags a memory transaction that never completes.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_pkg;

    localparam int unsigned AW          = 16;
    localparam int unsigned DW          = 16;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned CW_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Request latched at grant time and replayed to the memory system.
    typedef struct packed {
        logic          gnt;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the side not granted last time wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output logic grant
);

    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_I;
        end else if (update) begin
            last_q <= grant;
        end
    end

    always_comb begin
        grant = GNT_I;
        if (req_i && req_d) begin
            grant = ~last_q;
        end else if (req_d) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-port requests onto the shared cache/memory Rd/Wr/Done handshake.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_hit,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_hit,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_dataout,
    input  logic          mem_done,
    input  logic          mem_stall,
    input  logic          mem_cachehit,
    output logic          busy,
    output logic          err
);

    state_e        state_q;
    req_t          req_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] i_rdata_q, d_rdata_q;
    logic          i_done_q, d_done_q, i_hit_q, d_hit_q;
    logic          mem_rd_q, mem_wr_q, busy_q, err_q;

    logic          d_req_c, d_bad_c, grant_c, gnt_d_c, gnt_wr_c, tmo_c;
    logic          arb_req_i_c, arb_req_d_c, arb_upd_c;
    logic [CW-1:0] cnt_inc_c;

    assign d_bad_c   = d_rd & d_wr;
    assign d_req_c   = d_rd ^ d_wr;
    assign gnt_d_c   = (grant_c == GNT_D);
    assign gnt_wr_c  = gnt_d_c & d_wr;
    assign cnt_inc_c = cnt_q + CW'(1);
    assign tmo_c     = (cnt_inc_c == CW'(TIMEOUT));

    // Outside IDLE the arbiter only sees the granted side, so the RESP update records that side.
    assign arb_req_i_c = (state_q == ST_IDLE) ? i_req   : (req_q.gnt == GNT_I);
    assign arb_req_d_c = (state_q == ST_IDLE) ? d_req_c : (req_q.gnt == GNT_D);
    assign arb_upd_c   = (state_q == ST_RESP);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (arb_req_i_c),
        .req_d  (arb_req_d_c),
        .update (arb_upd_c),
        .grant  (grant_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_hit_q   <= 1'b0;
            d_hit_q   <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    err_q <= d_bad_c;
                    if (i_req || d_req_c) begin
                        req_q.gnt   <= grant_c;
                        req_q.wr    <= gnt_wr_c;
                        req_q.addr  <= gnt_d_c ? d_addr : i_addr;
                        req_q.wdata <= gnt_d_c ? d_wdata : '0;
                        mem_rd_q    <= ~gnt_wr_c;
                        mem_wr_q    <= gnt_wr_c;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_stall) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_inc_c;
                    if (mem_done) begin
                        if (req_q.gnt == GNT_D) begin
                            d_rdata_q <= mem_dataout;
                            d_hit_q   <= mem_cachehit;
                            d_done_q  <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_dataout;
                            i_hit_q   <= mem_cachehit;
                            i_done_q  <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end else if (tmo_c) begin
                        // Abandon the stuck transaction; the requester sees err instead of done.
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata    = i_rdata_q;
    assign i_done     = i_done_q;
    assign i_hit      = i_hit_q;
    assign d_rdata    = d_rdata_q;
    assign d_done     = d_done_q;
    assign d_hit      = d_hit_q;
    assign mem_addr   = req_q.addr;
    assign mem_datain = req_q.wdata;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a reactive memory-system model plus a transaction-level reference.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_datain, mem_dataout;
    logic        i_done, i_hit, d_done, d_hit, mem_rd, mem_wr;
    logic        mem_done, mem_stall, mem_cachehit, busy, err;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          rd_cycles;
        bit          stable;
    } acc_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cfg_stall, cfg_lat;
    bit          cfg_hit, cfg_hang;
    logic        ref_last;
    logic [15:0] env_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    acc_t        log_q [$];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_hit(i_hit),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_hit(d_hit),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_cachehit(mem_cachehit), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] rd_ref(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic acc_t pop_log();
        acc_t a;
        a.wr = 1'b0; a.addr = 16'h0; a.data = 16'h0; a.rd_cycles = 0; a.stable = 1'b0;
        if (log_q.size() > 0) a = log_q.pop_front();
        return a;
    endfunction

    // Memory system: stalls cfg_stall Rd/Wr cycles, then answers cfg_lat cycles after accepting.
    initial begin : mem_model
        bit   issuing, waiting;
        int   stall_left, wait_left;
        acc_t cur;
        issuing = 0; waiting = 0; stall_left = 0; wait_left = 0;
        cur.wr = 1'b0; cur.addr = 16'h0; cur.data = 16'h0; cur.rd_cycles = 0; cur.stable = 1'b0;
        mem_stall = 1'b0; mem_done = 1'b0; mem_dataout = 16'h0; mem_cachehit = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_done     = 1'b0;
            mem_dataout  = 16'($urandom);
            mem_cachehit = ~cfg_hit;
            if (rst) begin
                issuing = 0; waiting = 0; mem_stall = 1'b0;
            end else if (mem_rd || mem_wr) begin
                if (!issuing) begin
                    issuing = 1; waiting = 0; stall_left = cfg_stall;
                    cur.wr = mem_wr; cur.addr = mem_addr; cur.data = mem_datain;
                    cur.rd_cycles = 0; cur.stable = 1'b1;
                end
                cur.rd_cycles++;
                if (mem_addr !== cur.addr || mem_datain !== cur.data) cur.stable = 1'b0;
                if (stall_left > 0) begin
                    mem_stall = 1'b1;
                    stall_left--;
                end else begin
                    mem_stall = 1'b0;
                    issuing   = 0;
                    waiting   = !cfg_hang;
                    wait_left = cfg_lat;
                    if (cur.wr) env_mem[cur.addr] = cur.data;
                end
            end else if (waiting) begin
                if (mem_addr !== cur.addr || mem_datain !== cur.data) cur.stable = 1'b0;
                wait_left--;
                if (wait_left <= 0) begin
                    mem_done     = 1'b1;
                    mem_dataout  = env_mem.exists(cur.addr) ? env_mem[cur.addr] : dflt(cur.addr);
                    mem_cachehit = cfg_hit;
                    waiting      = 0;
                    log_q.push_back(cur);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; ref_last = GNT_I;
        log_q.delete();
    endtask

    // Raise the chosen requests together, hold each until its done, check order, latency and data.
    task automatic do_round(input bit fe, input logic [15:0] ia, input int dop,
                            input logic [15:0] da, input logic [15:0] dw,
                            input int s, input int lat, input bit hit, output bit first_d);
        int   k, one, want_i, want_d;
        bit   got_i, got_d, d_first_exp;
        acc_t a;
        cfg_stall = s; cfg_lat = lat; cfg_hit = hit; cfg_hang = 0;
        first_d = 0;
        @(posedge clk); #1;
        i_req = fe; i_addr = ia; d_rd = (dop == 1); d_wr = (dop == 2); d_addr = da; d_wdata = dw;
        d_first_exp = (dop != 0) && (!fe || ref_last == GNT_I);
        one    = 2 + s + lat;
        want_i = d_first_exp ? 2 * one + 1 : one;
        want_d = (d_first_exp || !fe) ? one : 2 * one + 1;
        k = 0; got_i = 0; got_d = 0;
        while (((fe && !got_i) || (dop != 0 && !got_d)) && k < 400) begin
            @(posedge clk); #1;
            k++;
            if (i_done && d_done) begin
                n_checks++; n_errors++;
                $display("FAIL both_done: i_done and d_done together at cycle %0d", k);
            end
            if (i_done) begin
                n_checks++;
                if (!fe || got_i) begin
                    n_errors++; $display("FAIL i_done_unexpected: pulse at cycle %0d", k);
                end else begin
                    got_i = 1; i_req = 1'b0; a = pop_log();
                    if (k !== want_i) begin n_errors++; $display("FAIL i_latency: got cycle %0d want %0d", k, want_i); end
                    n_checks++;
                    if (i_rdata !== rd_ref(ia)) begin n_errors++; $display("FAIL i_rdata: got %h want %h", i_rdata, rd_ref(ia)); end
                    n_checks++;
                    if (i_hit !== hit) begin n_errors++; $display("FAIL i_hit: got %b want %b", i_hit, hit); end
                    n_checks++;
                    if ({a.wr, a.addr, 8'(a.rd_cycles), a.stable} !== {1'b0, ia, 8'(s + 1), 1'b1}) begin
                        n_errors++;
                        $display("FAIL i_mem_access: got wr=%b addr=%h rd_cycles=%0d stable=%b want wr=0 addr=%h rd_cycles=%0d stable=1",
                                 a.wr, a.addr, a.rd_cycles, a.stable, ia, s + 1);
                    end
                    ref_last = GNT_I;
                end
            end
            if (d_done) begin
                n_checks++;
                if (dop == 0 || got_d) begin
                    n_errors++; $display("FAIL d_done_unexpected: pulse at cycle %0d", k);
                end else begin
                    got_d = 1; first_d = !got_i; d_rd = 1'b0; d_wr = 1'b0; a = pop_log();
                    if (k !== want_d) begin n_errors++; $display("FAIL d_latency: got cycle %0d want %0d", k, want_d); end
                    n_checks++;
                    if ({a.wr, a.addr, 8'(a.rd_cycles), a.stable} !== {(dop == 2), da, 8'(s + 1), 1'b1}) begin
                        n_errors++;
                        $display("FAIL d_mem_access: got wr=%b addr=%h rd_cycles=%0d stable=%b want wr=%0d addr=%h rd_cycles=%0d stable=1",
                                 a.wr, a.addr, a.rd_cycles, a.stable, dop == 2, da, s + 1);
                    end
                    n_checks++;
                    if (dop == 2) begin
                        if (a.data !== dw) begin n_errors++; $display("FAIL d_store_data: got %h want %h", a.data, dw); end
                        ref_mem[da] = dw;
                    end else if (d_rdata !== rd_ref(da)) begin
                        n_errors++; $display("FAIL d_rdata: got %h want %h", d_rdata, rd_ref(da));
                    end
                    n_checks++;
                    if (d_hit !== hit) begin n_errors++; $display("FAIL d_hit: got %b want %b", d_hit, hit); end
                    ref_last = GNT_D;
                end
            end
        end
        n_checks++;
        if (k >= 400) begin n_errors++; $display("FAIL round_timeout: done not seen within %0d cycles", k); end
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({i_done, d_done, busy} !== 3'b000) begin
            n_errors++; $display("FAIL post_round: got i_done=%b d_done=%b busy=%b want 000", i_done, d_done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({i_rdata, d_rdata, mem_addr, mem_datain} !== 64'h0) begin
            n_errors++; $display("FAIL reset_data: got %h want 0", {i_rdata, d_rdata, mem_addr, mem_datain});
        end
        n_checks++;
        if ({i_done, i_hit, d_done, d_hit, mem_rd, mem_wr, busy, err} !== 8'h0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b want 00000000", {i_done, i_hit, d_done, d_hit, mem_rd, mem_wr, busy, err});
        end
        rst = 1'b0; ref_last = GNT_I;
        @(posedge clk); #1;
        n_checks++;
        if ({mem_rd, mem_wr, busy, err} !== 4'h0) begin
            n_errors++; $display("FAIL idle_after_reset: got %b want 0000", {mem_rd, mem_wr, busy, err});
        end
    endtask

    task automatic test_lone_fetch();
        bit fd;
        env_mem[16'h0040] = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;
        do_round(1'b1, 16'h0040, 0, 16'h0, 16'h0, 0, 2, 1'b1, fd);
    endtask

    task automatic test_tie();
        bit fd;
        do_reset();
        do_round(1'b1, 16'h0010, 1, 16'h2000, 16'h0, 0, 2, 1'b1, fd);
        n_checks++;
        if (fd !== 1'b1) begin n_errors++; $display("FAIL tie_after_reset: got d_first=%b want 1", fd); end
        do_round(1'b1, 16'h0010, 1, 16'h2000, 16'h0, 0, 2, 1'b0, fd);
        n_checks++;
        if (fd !== 1'b1) begin n_errors++; $display("FAIL tie_after_i: got d_first=%b want 1", fd); end
        do_round(1'b0, 16'h0, 1, 16'h2002, 16'h0, 0, 2, 1'b1, fd);
        do_round(1'b1, 16'h0012, 1, 16'h2004, 16'h0, 1, 3, 1'b1, fd);
        n_checks++;
        if (fd !== 1'b0) begin n_errors++; $display("FAIL tie_after_d: got d_first=%b want 0", fd); end
    endtask

    task automatic test_store_stall();
        bit fd;
        do_round(1'b0, 16'h0, 2, 16'h1234, 16'h00A5, 3, 2, 1'b1, fd);
        do_round(1'b0, 16'h0, 1, 16'h1234, 16'h0, 0, 2, 1'b1, fd);
        do_round(1'b1, 16'h1234, 0, 16'h0, 16'h0, 0, 1, 1'b0, fd);
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        i_req = 1'b0; d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0777;
        @(posedge clk); #1;
        d_rd = 1'b0; d_wr = 1'b0;
        n_checks++;
        if ({err, busy, mem_rd, mem_wr} !== 4'b1000) begin
            n_errors++; $display("FAIL illegal_err: got err/busy/rd/wr=%b want 1000", {err, busy, mem_rd, mem_wr});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({err, busy, mem_rd, mem_wr} !== 4'b0000) begin
            n_errors++; $display("FAIL illegal_after: got err/busy/rd/wr=%b want 0000", {err, busy, mem_rd, mem_wr});
        end
    endtask

    task automatic test_watchdog();
        int k;
        bit done_seen, fd;
        cfg_stall = 0; cfg_hang = 1;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0300;
        k = 0; done_seen = 0;
        while (err !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (i_done || d_done) done_seen = 1;
        end
        i_req = 1'b0;
        n_checks++;
        if (k !== 66) begin n_errors++; $display("FAIL watchdog_cycle: err at cycle %0d want 66", k); end
        n_checks++;
        if ({done_seen, busy} !== 2'b00) begin
            n_errors++; $display("FAIL watchdog_state: got done_seen=%b busy=%b want 00", done_seen, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({err, busy} !== 2'b00) begin n_errors++; $display("FAIL watchdog_pulse: got err/busy=%b want 00", {err, busy}); end
        cfg_hang = 0;
        do_round(1'b1, 16'h0302, 0, 16'h0, 16'h0, 0, 2, 1'b1, fd);
    endtask

    task automatic test_reset_in_wait();
        bit bad;
        cfg_stall = 0; cfg_lat = 20; cfg_hang = 0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0500;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, mem_addr} !== {1'b1, 16'h0500}) begin
            n_errors++; $display("FAIL wait_before_reset: got busy=%b addr=%h want 1 0500", busy, mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({i_rdata, d_rdata, mem_addr, mem_datain, i_done, i_hit, d_done, d_hit, mem_rd, mem_wr, busy, err} !== 72'h0) begin
            n_errors++; $display("FAIL async_reset: outputs not cleared, busy=%b mem_addr=%h", busy, mem_addr);
        end
        i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; ref_last = GNT_I;
        log_q.delete();
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (i_done || d_done || busy || err) bad = 1;
        end
        n_checks++;
        if (bad !== 1'b0) begin n_errors++; $display("FAIL reset_discard: got activity=%b want 0", bad); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            bit fe, fd;
            int dop;
            fe  = 1'($urandom_range(0, 1));
            dop = int'($urandom_range(0, 2));
            if (!fe && dop == 0) fe = 1'b1;
            do_round(fe, 16'($urandom_range(0, 15)), dop, 16'($urandom_range(0, 15)), 16'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), fd);
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 16'h0; d_rd = 1'b0; d_wr = 1'b0;
        d_addr = 16'h0; d_wdata = 16'h0;
        cfg_stall = 0; cfg_lat = 2; cfg_hit = 1'b1; cfg_hang = 1'b0; ref_last = GNT_I;
        test_reset();
        test_lone_fetch();
        test_tie();
        test_store_stall();
        test_illegal();
        test_watchdog();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
